// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one synchronous single-port word memory between
// instruction fetch, load/store data and a debug/loader port. Data beats
// fetch unless fetch has been starved for STARVE_MAX cycles. A freeze
// handshake (RUN -> DRAIN -> FROZEN -> RUN) gives the debug port exclusive
// access while core traffic is held off.
module mips_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          freeze_req,
  output logic          freeze_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {RUN, DRAIN, FROZEN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D, OWN_DBG} owner_t;

  state_t          state, state_nxt;
  owner_t          pend, pend_nxt;
  logic [CW-1:0]   starve_cnt, starve_nxt;
  logic [DW-1:0]   if_rdata_q, d_rdata_q, dbg_rdata_q;

  // Grant selection and freeze FSM next state; grants are suppressed while reset is held
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    dbg_gnt   = 1'b0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (freeze_req) begin
            state_nxt = DRAIN;
          end else if (d_req && !(if_req && starve_cnt == STARVE_LIM)) begin
            d_gnt = 1'b1;
          end else if (if_req) begin
            if_gnt = 1'b1;
          end
        end
        DRAIN: begin
          if (pend == OWN_NONE) state_nxt = FROZEN;
        end
        FROZEN: begin
          if (!freeze_req) begin
            if (pend != OWN_DBG) state_nxt = RUN;
          end else if (dbg_req) begin
            dbg_gnt = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Memory strobe/bus mux from the winner, read-owner tracking and starvation count
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    pend_nxt   = OWN_NONE;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      pend_nxt = OWN_IF;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      if (!d_we) pend_nxt = OWN_D;
    end else if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      if (!dbg_we) pend_nxt = OWN_DBG;
    end
    if (!if_req || if_gnt) begin
      starve_nxt = '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_nxt = starve_cnt + 1'b1;
    end else begin
      starve_nxt = starve_cnt;
    end
  end

  // State, pending read owner and starvation counter registers
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pend       <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      pend       <= pend_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Read-data holding registers so each requester keeps its last returned word
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (pend == OWN_IF)  if_rdata_q  <= mem_rdata;
      if (pend == OWN_D)   d_rdata_q   <= mem_rdata;
      if (pend == OWN_DBG) dbg_rdata_q <= mem_rdata;
    end
  end

  assign if_rvalid  = (pend == OWN_IF);
  assign d_rvalid   = (pend == OWN_D);
  assign dbg_rvalid = (pend == OWN_DBG);
  assign if_rdata   = if_rvalid  ? mem_rdata : if_rdata_q;
  assign d_rdata    = d_rvalid   ? mem_rdata : d_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;
  assign freeze_ack = (state == FROZEN);

endmodule
